// File: rtl/drum_pkg.sv
// drum_pkg: shared BPM defaults, step threshold helper and sequencer state encoding
package drum_pkg;
   localparam int DEF_BPM_RESET = 140;
   localparam int DEF_BPM_MIN   = 40;
   localparam int DEF_BPM_MAX   = 250;
   localparam int DEF_BPM_INC   = 5;
   typedef enum logic [1:0] {IDLE, START, RUN} state_t;
   // one sixteenth note is 60/(4*bpm) s, so accumulating bpm per cycle crosses clk_hz*15
   function automatic longint step_thr(input longint clk_hz);
      return clk_hz * 15;
   endfunction
endpackage

// File: rtl/step_clock.sv
// step_clock: divider-free phase accumulator producing the sixteenth-note step tick
module step_clock
   import drum_pkg::*;
#(
   parameter longint THR     = 750000000,
   parameter int     BPM_MAX = DEF_BPM_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] bpm,
   output logic       step_tick
);
   localparam int AW = $clog2(THR + BPM_MAX) + 1;
   localparam logic [AW-1:0] THR_V = AW'(THR);
   logic [AW-1:0] acc;
   logic [AW-1:0] sum;
   assign sum = acc + AW'(bpm);
   assign step_tick = enable && sum >= THR_V;
   always_ff @(posedge clk)
      if (rst || !enable) acc <= '0;
      else acc <= step_tick ? sum - THR_V : sum;
endmodule

// File: rtl/drum_sequencer.sv
// drum_sequencer: N-channel step sequencer with bar-aligned pattern switching and saturating BPM
module drum_sequencer
   import drum_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int N_CH       = 4,
   parameter int N_STEPS    = 16,
   parameter int N_PATTERNS = 4,
   parameter int BPM_RESET  = DEF_BPM_RESET,
   parameter int BPM_MIN    = DEF_BPM_MIN,
   parameter int BPM_MAX    = DEF_BPM_MAX,
   parameter int BPM_INC    = DEF_BPM_INC
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          run,
   input  logic                          bpm_up,
   input  logic                          bpm_dn,
   input  logic [$clog2(N_PATTERNS)-1:0] pat_sel,
   input  logic                          wr_en,
   input  logic [$clog2(N_PATTERNS)-1:0] wr_pat,
   input  logic [$clog2(N_STEPS)-1:0]    wr_step,
   input  logic [N_CH-1:0]               wr_data,
   output logic [7:0]                    bpm_value,
   output logic [$clog2(N_PATTERNS)-1:0] active_pat,
   output logic [$clog2(N_STEPS)-1:0]    step_idx,
   output logic [N_CH-1:0]               trig,
   output logic                          bar_start,
   output logic                          playing
);
   localparam int PW = $clog2(N_PATTERNS);
   localparam int SW = $clog2(N_STEPS);
   localparam longint THR = step_thr(CLK_HZ);
   localparam logic [7:0] B_RST = 8'(BPM_RESET);
   localparam logic [7:0] B_MIN = 8'(BPM_MIN);
   localparam logic [7:0] B_MAX = 8'(BPM_MAX);
   localparam logic [7:0] B_INC = 8'(BPM_INC);
   localparam logic [SW-1:0] FIRST = '0;
   localparam logic [SW-1:0] LAST = SW'(N_STEPS - 1);
   state_t state;
   logic [N_CH-1:0] mem [N_PATTERNS][N_STEPS];
   logic [PW-1:0] pending;
   logic [PW-1:0] nxt_pat;
   logic [SW-1:0] nxt_step;
   logic [7:0] bpm_nxt;
   logic step_tick;
   logic wrap;
   assign playing  = state == RUN;
   assign wrap     = step_idx == LAST;
   assign nxt_step = wrap ? FIRST : step_idx + 1'b1;
   // the queued pattern only takes over on the tick that starts a new bar
   assign nxt_pat  = wrap ? pending : active_pat;
   assign bpm_nxt  = bpm_up && !bpm_dn ? (bpm_value > B_MAX - B_INC ? B_MAX : bpm_value + B_INC) :
                     bpm_dn && !bpm_up ? (bpm_value < B_MIN + B_INC ? B_MIN : bpm_value - B_INC) :
                     bpm_value;
   step_clock #(.THR(THR), .BPM_MAX(BPM_MAX)) u_step_clock (
      .clk       (clk),
      .rst       (rst),
      .enable    (playing && run),
      .bpm       (bpm_value),
      .step_tick (step_tick)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bpm_value  <= B_RST;
         active_pat <= '0;
         pending    <= '0;
         step_idx   <= '0;
         trig       <= '0;
         bar_start  <= 1'b0;
      end else begin
         bpm_value <= bpm_nxt;
         pending   <= pat_sel;
         trig      <= '0;
         bar_start <= 1'b0;
         if (state == IDLE) begin
            active_pat <= pat_sel;
            step_idx   <= '0;
            state      <= run ? START : IDLE;
         end else if (state == START) begin
            trig      <= mem[active_pat][FIRST];
            bar_start <= 1'b1;
            state     <= RUN;
         end else if (!run) begin
            step_idx <= '0;
            state    <= IDLE;
         end else if (step_tick) begin
            step_idx   <= nxt_step;
            trig       <= mem[nxt_pat][nxt_step];
            bar_start  <= wrap;
            active_pat <= nxt_pat;
         end
      end
   end
   // reads above see pre-write contents, so a same-cycle write lands on the next pass
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < N_PATTERNS; p++)
            for (int s = 0; s < N_STEPS; s++)
               mem[p][s] <= '0;
      end else if (wr_en) begin
         mem[wr_pat][wr_step] <= wr_data;
      end
   end
endmodule
